// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI command-decoded RAM slave: opcodes, FSM states, frame layout.
package spi_ram_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Opcode sits directly above the DATA_W-bit payload in each frame.
  function automatic int unsigned op_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
module spi_ram_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM slave behind an SPI slave; read data returned over valid/ready.
// Optional macro SPI_RAM_AUTO_INC_EN: pointers post-increment on WR_DATA / each read.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int unsigned OP_LSB = op_lsb(DATA_W);

  if (ADDR_W > DATA_W) begin : g_param_check
    $error("spi_ram_ctrl: ADDR_W must not exceed DATA_W");
  end

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              tx_valid_nxt;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;

  assign cmd     = cmd_e'(rx_data[OP_LSB +: OP_W]);
  assign payload = rx_data[DATA_W-1:0];
  assign accept  = rx_valid && rx_ready;

  // State and registered outputs; rx_ready/busy track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      rx_ready <= (state_nxt == ST_IDLE);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, pointer and memory-port decode.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = rd_ptr;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_WR_ADDR: wr_ptr_nxt = payload[ADDR_W-1:0];
            CMD_WR_DATA: begin
              mem_we   = 1'b1;
              mem_addr = wr_ptr;
`ifdef SPI_RAM_AUTO_INC_EN
              wr_ptr_nxt = wr_ptr + ADDR_W'(1);
`endif
            end
            CMD_RD_ADDR: rd_ptr_nxt = payload[ADDR_W-1:0];
            CMD_RD_DATA: begin
              // RAM read launched at the accepting edge; data is ready in ST_RD.
              mem_re    = 1'b1;
              mem_addr  = rd_ptr;
              state_nxt = ST_RD;
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RD: begin
        tx_data_nxt  = mem_rdata;
        tx_valid_nxt = 1'b1;
        state_nxt    = ST_HOLD;
`ifdef SPI_RAM_AUTO_INC_EN
        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
`endif
      end
      ST_HOLD: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  spi_ram_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(payload),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: vector table plus hand-written corner sequences.
module tb_spi_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy;

  logic [17:0] rx_data16;
  logic        rx_valid16, rx_ready16;
  logic [15:0] tx_data16;
  logic        tx_valid16, tx_ready16, busy16;

  int n_tests = 0;
  int n_fail  = 0;

  spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  spi_ram_ctrl #(.ADDR_W(4), .DATA_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ready(rx_ready16),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16), .busy(busy16)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] payload;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    int k = 0;
    @(negedge clk);
    while (!rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) check("send_ready_timeout", 32'(rx_ready), 32'd1);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] exp, input string name);
    tx_ready = 1'b1;
    send(2'b11, 8'h00);
    check({name, "_rd_valid"}, 32'(tx_valid), 32'd0);
    check({name, "_rd_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(tx_valid), 32'd1);
    check({name, "_data"}, 32'(tx_data), 32'(exp));
    @(posedge clk); #1;
    check({name, "_valid_drop"}, 32'(tx_valid), 32'd0);
    check({name, "_ready_back"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic send16(input logic [1:0] op, input logic [15:0] pl);
    int k = 0;
    @(negedge clk);
    while (!rx_ready16 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready16) check("send16_ready_timeout", 32'(rx_ready16), 32'd1);
    rx_data16  = {op, pl};
    rx_valid16 = 1'b1;
    @(posedge clk);
    #1 rx_valid16 = 1'b0;
  endtask

  task automatic read16(input logic [15:0] exp, input string name);
    tx_ready16 = 1'b1;
    send16(2'b11, 16'h0000);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(tx_valid16), 32'd1);
    check({name, "_data"}, 32'(tx_data16), 32'(exp));
    @(posedge clk); #1;
    check({name, "_valid_drop"}, 32'(tx_valid16), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_wrap [3];
    logic [7:0] exp_mem0;

    vecs.push_back('{2'b00, 8'h3C, 8'h00});
    vecs.push_back('{2'b01, 8'hA5, 8'h00});
    vecs.push_back('{2'b10, 8'h3C, 8'h00});
    vecs.push_back('{2'b11, 8'h00, 8'hA5});
    vecs.push_back('{2'b00, 8'h10, 8'h00});
    vecs.push_back('{2'b01, 8'h5A, 8'h00});
    vecs.push_back('{2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b01, 8'hFF, 8'h00});
    vecs.push_back('{2'b00, 8'hFF, 8'h00});
    vecs.push_back('{2'b01, 8'hC3, 8'h00});
    vecs.push_back('{2'b10, 8'h10, 8'h00});
    vecs.push_back('{2'b11, 8'h00, 8'h5A});
    vecs.push_back('{2'b10, 8'h00, 8'h00});
    vecs.push_back('{2'b11, 8'h00, 8'hFF});
    vecs.push_back('{2'b10, 8'hFF, 8'h00});
    vecs.push_back('{2'b11, 8'h00, 8'hC3});
    vecs.push_back('{2'b00, 8'h20, 8'h00});
    vecs.push_back('{2'b01, 8'h77, 8'h00});
    vecs.push_back('{2'b10, 8'h20, 8'h00});
    vecs.push_back('{2'b11, 8'h00, 8'h77});
    vecs.push_back('{2'b01, 8'h88, 8'h00});
    vecs.push_back('{2'b11, 8'h00, 8'h88});

`ifdef SPI_RAM_AUTO_INC_EN
    exp_wrap = '{8'h11, 8'h22, 8'h33};
    exp_mem0 = 8'h33;
`else
    exp_wrap = '{8'h33, 8'h33, 8'h33};
    exp_mem0 = 8'hFF;
`endif

    rst        = 1'b1;
    rx_data    = '0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    rx_data16  = '0;
    rx_valid16 = 1'b0;
    tx_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rx_ready", 32'(rx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset16_tx_data", 32'(tx_data16), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].op == 2'b11) do_read(vecs[i].exp, $sformatf("vec%0d", i));
      else send(vecs[i].op, vecs[i].payload);
    end

    // Backpressure: held read data, and a frame waiting until after the handshake.
    send(2'b00, 8'h40);
    send(2'b10, 8'h10);
    tx_ready = 1'b0;
    send(2'b11, 8'h00);
    @(posedge clk); #1;
    check("bp_valid", 32'(tx_valid), 32'd1);
    check("bp_data", 32'(tx_data), 32'h5A);
    @(negedge clk);
    rx_data  = {2'b01, 8'h99};
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid%0d", i), 32'(tx_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", i), 32'(tx_data), 32'h5A);
      check($sformatf("bp_hold_rx_ready%0d", i), 32'(rx_ready), 32'd0);
    end
    @(negedge clk);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake_valid", 32'(tx_valid), 32'd0);
    check("bp_handshake_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    send(2'b10, 8'h40);
    do_read(8'h99, "bp_pending_write");

    // Write burst across the top of the address space.
    send(2'b00, 8'hFE);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b01, 8'h33);
    send(2'b10, 8'hFE);
    for (int i = 0; i < 3; i++) do_read(exp_wrap[i], $sformatf("wrap%0d", i));

    // Reset while holding read data.
    send(2'b10, 8'h3C);
    tx_ready = 1'b0;
    send(2'b11, 8'h00);
    @(posedge clk); #1;
    check("rst_pre_valid", 32'(tx_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_data", 32'(tx_data), 32'd0);
    check("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_read(exp_mem0, "rst_rd_ptr0");
    send(2'b01, 8'h6D);
    send(2'b10, 8'h00);
    do_read(8'h6D, "rst_wr_ptr0");
    send(2'b10, 8'h3C);
    do_read(8'hA5, "rst_mem_kept");

    // Narrow address / wide data instance; upper address payload bits ignored.
    send16(2'b00, 16'hABCF);
    send16(2'b01, 16'hBEEF);
    send16(2'b00, 16'hFFF0);
    send16(2'b01, 16'h1234);
    send16(2'b10, 16'h123F);
    read16(16'hBEEF, "p16_addrF");
    send16(2'b10, 16'h0000);
    read16(16'h1234, "p16_addr0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
